// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic P_CORE = 1'b0;
  localparam logic P_DMA  = 1'b1;

  // Callers zero-extend their address to 64 bits before the check.
  function automatic logic addr_in_range(input logic [63:0] addr, input int unsigned aw);
    return (addr >> aw) == 64'd0;
  endfunction

endpackage

// File: rtl/rr_burst_arbiter.sv
// Two-way round-robin arbiter with bounded bursts; grants are combinational from req.
// A port keeps ownership under contention for at most BURST_MAX consecutive grants.
module rr_burst_arbiter
  import dmem_pkg::*;
#(
  parameter int BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic [3:0] BMAX_M1 = 4'(BURST_MAX - 1);

  state_t     r_state;
  logic       r_rr_last;
  logic [3:0] r_burst_cnt;

  logic   w_any;
  logic   w_sel;
  logic   w_at_limit;
  state_t w_next_own;

  always_comb begin
    w_any      = req0 | req1;
    w_at_limit = (r_burst_cnt >= BMAX_M1);
    w_sel      = P_CORE;
    if (req0 && req1) begin
      case (r_state)
        OWN0:    w_sel = w_at_limit ? P_DMA : P_CORE;
        OWN1:    w_sel = w_at_limit ? P_CORE : P_DMA;
        default: w_sel = ~r_rr_last;
      endcase
    end else if (req1) begin
      w_sel = P_DMA;
    end
    w_next_own = (w_sel == P_DMA) ? OWN1 : OWN0;
    gnt0 = w_any && (w_sel == P_CORE);
    gnt1 = w_any && (w_sel == P_DMA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_last   <= P_DMA;
      r_burst_cnt <= 4'd0;
    end else if (!w_any) begin
      r_state     <= IDLE;
      r_burst_cnt <= 4'd0;
    end else begin
      r_state   <= w_next_own;
      r_rr_last <= w_sel;
      // Count consecutive grants to the same owner; an owner change restarts it.
      if (r_state == w_next_own)
        r_burst_cnt <= w_at_limit ? BMAX_M1 : r_burst_cnt + 4'd1;
      else
        r_burst_cnt <= 4'd0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates core and DMA ports onto a single-ported data memory, one access per cycle.
// Reads return registered data one cycle after grant; losers stall by holding req until gnt.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] a0,
  input  logic [DATA_WIDTH-1:0] a1,
  input  logic [DATA_WIDTH-1:0] wd0,
  input  logic [DATA_WIDTH-1:0] wd1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rd0,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic                  err0,
  output logic                  err1,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  logic                  w_we;
  logic                  w_in_range;
  logic                  w_rd_gnt0;
  logic                  w_rd_gnt1;
  logic [DATA_WIDTH-1:0] w_rdata;

  logic                  r_rvalid0, r_rvalid1;
  logic                  r_err0, r_err1;
  logic [DATA_WIDTH-1:0] r_rd0, r_rd1;

  rr_burst_arbiter #(
    .BURST_MAX(BURST_MAX)
  ) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req0),
    .req1 (req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Port 0 is the idle default on the memory bus.
  always_comb begin
    mem_a      = gnt1 ? a1 : a0;
    mem_wd     = gnt1 ? wd1 : wd0;
    w_we       = (gnt0 & we0) | (gnt1 & we1);
    w_in_range = addr_in_range(64'(mem_a), ADDR_WIDTH);
    mem_we     = w_we & w_in_range;
    w_rd_gnt0  = gnt0 & ~we0;
    w_rd_gnt1  = gnt1 & ~we1;
    w_rdata    = w_in_range ? mem_rd : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_err0    <= 1'b0;
      r_err1    <= 1'b0;
      r_rd0     <= '0;
      r_rd1     <= '0;
    end else begin
      r_rvalid0 <= w_rd_gnt0;
      r_rvalid1 <= w_rd_gnt1;
      r_err0    <= gnt0 & ~w_in_range;
      r_err1    <= gnt1 & ~w_in_range;
      if (w_rd_gnt0) r_rd0 <= w_rdata;
      if (w_rd_gnt1) r_rd1 <= w_rdata;
    end
  end

  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign err0    = r_err0;
  assign err1    = r_err1;
  assign rd0     = r_rd0;
  assign rd1     = r_rd1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a local 32-word memory behind the arbiter.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_we;
  logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [32];
  logic        mem_init = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h100 + 32'(i);
    end else if (mem_we) begin
      mem[mem_a[4:0]] <= mem_wd;
    end
  end
  assign mem_rd = mem[mem_a[4:0]];

  dmem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BURST_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rd0(rd0), .rd1(rd1), .err0(err0), .err1(err1),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        g0, g1, mwe, rv0, rv1;
    logic [31:0] rd0, rd1;
    logic        e0, e1;
  } vec_t;

  vec_t vt [13];
  int   gseq [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r0_, w0_, input logic [31:0] ad0, d0_,
                       input logic r1_, w1_, input logic [31:0] ad1, d1_);
    req0 = r0_; we0 = w0_; a0 = ad0; wd0 = d0_;
    req1 = r1_; we1 = w1_; a1 = ad1; wd1 = d1_;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vt[0]  = '{1,1,32'd3,32'hDEADBEEF, 0,0,0,0, 1,0,1, 0,0, 32'h0,32'h0, 0,0};
    vt[1]  = '{1,0,32'd3,0, 0,0,0,0, 1,0,0, 0,0, 32'h0,32'h0, 0,0};
    vt[2]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 1,0, 32'hDEADBEEF,32'h0, 0,0};
    vt[3]  = '{0,0,0,0, 1,1,32'h20,32'hCAFE, 0,1,0, 0,0, 32'hDEADBEEF,32'h0, 0,0};
    vt[4]  = '{0,0,0,0, 1,0,32'h20,0, 0,1,0, 0,0, 32'hDEADBEEF,32'h0, 0,1};
    vt[5]  = '{1,1,32'd7,32'h1, 0,0,0,0, 1,0,1, 0,1, 32'hDEADBEEF,32'h0, 0,1};
    vt[6]  = '{0,0,0,0, 1,0,32'd7,0, 0,1,0, 0,0, 32'hDEADBEEF,32'h0, 0,0};
    vt[7]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,1, 32'hDEADBEEF,32'h1, 0,0};
    vt[8]  = '{0,0,0,0, 1,0,32'd5,0, 0,1,0, 0,0, 32'hDEADBEEF,32'h1, 0,0};
    vt[9]  = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,1, 32'hDEADBEEF,32'h105, 0,0};
    vt[10] = '{1,0,32'h40000003,0, 0,0,0,0, 1,0,0, 0,0, 32'hDEADBEEF,32'h105, 0,0};
    vt[11] = '{0,0,0,0, 0,0,0,0, 0,0,0, 1,0, 32'h0,32'h105, 1,0};
    vt[12] = '{0,0,0,0, 0,0,0,0, 0,0,0, 0,0, 32'h0,32'h105, 0,0};
    gseq = '{0,0,0,0,1,1,1,1,0,0};

    // Reset state
    do_reset();
    mem_init = 1'b0;
    #2;
    chk("rst_gnt0", {31'd0, gnt0}, 0);
    chk("rst_gnt1", {31'd0, gnt1}, 0);
    chk("rst_rvalid0", {31'd0, rvalid0}, 0);
    chk("rst_rvalid1", {31'd0, rvalid1}, 0);
    chk("rst_rd0", rd0, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_err", {30'd0, err1, err0}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);

    // Single-port reads/writes, out-of-range, write-then-read
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
      #2;
      chk($sformatf("v%0d_gnt0", i), {31'd0, gnt0}, {31'd0, vt[i].g0});
      chk($sformatf("v%0d_gnt1", i), {31'd0, gnt1}, {31'd0, vt[i].g1});
      chk($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vt[i].mwe});
      chk($sformatf("v%0d_mem_a", i), mem_a, vt[i].g1 ? vt[i].a1 : vt[i].a0);
      chk($sformatf("v%0d_rvalid0", i), {31'd0, rvalid0}, {31'd0, vt[i].rv0});
      chk($sformatf("v%0d_rvalid1", i), {31'd0, rvalid1}, {31'd0, vt[i].rv1});
      chk($sformatf("v%0d_rd0", i), rd0, vt[i].rd0);
      chk($sformatf("v%0d_rd1", i), rd1, vt[i].rd1);
      chk($sformatf("v%0d_err0", i), {31'd0, err0}, {31'd0, vt[i].e0});
      chk($sformatf("v%0d_err1", i), {31'd0, err1}, {31'd0, vt[i].e1});
    end
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("mem%0d", i), mem[i],
          (i == 3) ? 32'hDEADBEEF : (i == 7) ? 32'h1 : 32'h100 + 32'(i));
    end

    // First contention from reset
    do_reset();
    drive(1, 0, 32'd1, 0, 1, 0, 32'd2, 0);
    for (int c = 0; c < 10; c++) begin
      #2;
      chk($sformatf("cont%0d_gnt0", c), {31'd0, gnt0}, (gseq[c] == 0) ? 1 : 0);
      chk($sformatf("cont%0d_gnt1", c), {31'd0, gnt1}, (gseq[c] == 1) ? 1 : 0);
      chk($sformatf("cont%0d_excl", c), {31'd0, gnt0 & gnt1}, 0);
      @(negedge clk);
    end

    // Burst release: port 1 alone, then port 0 joins
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 32'd2, 0);
    for (int c = 0; c < 6; c++) begin
      #2;
      chk($sformatf("solo%0d_gnt1", c), {31'd0, gnt1}, 1);
      @(negedge clk);
    end
    drive(1, 0, 32'd1, 0, 1, 0, 32'd2, 0);
    for (int c = 0; c < 10; c++) begin
      #2;
      chk($sformatf("rel%0d_gnt0", c), {31'd0, gnt0}, (gseq[c] == 0) ? 1 : 0);
      chk($sformatf("rel%0d_gnt1", c), {31'd0, gnt1}, (gseq[c] == 1) ? 1 : 0);
      @(negedge clk);
    end

    // Reset while a read response is outstanding
    do_reset();
    drive(1, 0, 32'd3, 0, 0, 0, 0, 0);
    #2;
    chk("mr_gnt0", {31'd0, gnt0}, 1);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mr_rvalid0_pre", {31'd0, rvalid0}, 1);
    chk("mr_rd0_pre", rd0, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("mr_rvalid", {30'd0, rvalid1, rvalid0}, 0);
    chk("mr_rd0", rd0, 0);
    chk("mr_rd1", rd1, 0);
    chk("mr_err", {30'd0, err1, err0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1, 0, 32'd1, 0, 1, 0, 32'd2, 0);
    #2;
    chk("mr_first_gnt0", {31'd0, gnt0}, 1);
    chk("mr_first_gnt1", {31'd0, gnt1}, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
